// File: rtl/fila_pkg.sv
// Shared types and constants for the FIFO sequencing/arbitration controller.
package fila_pkg;

    localparam int FILA_DEPTH = 8;
    localparam int FILA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } estado_esc_t;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        C  = 2'd2
    } req_id_t;

    // Round-robin successor in the fixed order P0 -> P1 -> C -> P0.
    function automatic req_id_t rr_next(input req_id_t id);
        case (id)
            P0:      return P1;
            P1:      return C;
            default: return P0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin pick: search starts just after the last
// granted requester and takes the first eligible one.
module rr_arbiter3
    import fila_pkg::*;
(
    input  logic [2:0] elig,
    input  req_id_t    last,
    output logic [2:0] grant,
    output logic       valid
);

    req_id_t cand0;
    req_id_t cand1;
    req_id_t cand2;

    always_comb begin
        cand0 = rr_next(last);
        cand1 = rr_next(cand0);
        cand2 = rr_next(cand1);
        grant = 3'b000;
        if (elig[cand0]) begin
            grant[cand0] = 1'b1;
        end else if (elig[cand1]) begin
            grant[cand1] = 1'b1;
        end else if (elig[cand2]) begin
            grant[cand2] = 1'b1;
        end
        valid = |elig;
    end

endmodule

// File: rtl/escalonador_fila.sv
// Shares the FIFO's single enqueue/dequeue port between two producers and one
// consumer, with a shadow occupancy count that blocks overflow and underflow.
//
// state | meaning
// IDLE  | arbitrate among eligible requesters, latch winner and data
// ISSUE | one-cycle enqueue/dequeue command to the FIFO
// HOLD  | wait GAP-1 cycles for the FIFO to turn around
// DONE  | pulse ack/valid, update shadow count
module escalonador_fila
    import fila_pkg::*;
#(
    parameter int DEPTH = FILA_DEPTH,
    parameter int GAP   = 4
) (
    input  logic                  clock_10KHz,
    input  logic                  reset,
    input  logic                  prod0_req,
    input  logic                  prod1_req,
    input  logic [FILA_WIDTH-1:0] prod0_data,
    input  logic [FILA_WIDTH-1:0] prod1_data,
    output logic                  prod0_ack,
    output logic                  prod1_ack,
    input  logic                  cons_req,
    output logic                  cons_valid,
    output logic [FILA_WIDTH-1:0] cons_data,
    output logic [FILA_WIDTH-1:0] fila_data_in,
    output logic                  fila_enqueue,
    output logic                  fila_dequeue,
    input  logic [FILA_WIDTH-1:0] fila_data_out,
    output logic [3:0]            count,
    output logic                  full,
    output logic                  empty
);

    localparam int              CW        = (GAP > 2) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0]   HOLD_LOAD = CW'(GAP - 2);
    localparam logic [3:0]      DEPTH_C   = 4'(DEPTH);

    estado_esc_t           state_q;
    estado_esc_t           state_d;
    req_id_t               last_q;
    req_id_t               win_q;
    req_id_t               win_d;
    logic [CW-1:0]         hold_q;
    logic [3:0]            count_q;
    logic [FILA_WIDTH-1:0] data_q;
    logic [FILA_WIDTH-1:0] cons_q;
    logic [2:0]            elig;
    logic [2:0]            grant;
    logic                  grant_valid;

    assign count        = count_q;
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == 4'd0);
    assign fila_data_in = data_q;
    assign cons_data    = cons_q;

    // Bit order matches req_id_t: P0, P1, C.
    assign elig = {cons_req & ~empty, prod1_req & ~full, prod0_req & ~full};

    rr_arbiter3 u_rr (
        .elig  (elig),
        .last  (last_q),
        .grant (grant),
        .valid (grant_valid)
    );

    always_comb begin
        win_d = P0;
        if (grant[1]) begin
            win_d = P1;
        end else if (grant[2]) begin
            win_d = C;
        end
    end

    always_ff @(posedge clock_10KHz or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = ISSUE;
            ISSUE:   state_d = HOLD;
            HOLD:    if (hold_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fila_enqueue = 1'b0;
        fila_dequeue = 1'b0;
        prod0_ack    = 1'b0;
        prod1_ack    = 1'b0;
        cons_valid   = 1'b0;
        if (state_q == ISSUE) begin
            fila_enqueue = (win_q != C);
            fila_dequeue = (win_q == C);
        end
        if (state_q == DONE) begin
            prod0_ack  = (win_q == P0);
            prod1_ack  = (win_q == P1);
            cons_valid = (win_q == C);
        end
    end

    always_ff @(posedge clock_10KHz or negedge reset) begin
        if (!reset) begin
            last_q  <= C;
            win_q   <= P0;
            hold_q  <= '0;
            count_q <= 4'd0;
            data_q  <= '0;
            cons_q  <= '0;
        end else begin
            if (state_q == IDLE && grant_valid) begin
                last_q <= win_d;
                win_q  <= win_d;
                if (win_d == P0) begin
                    data_q <= prod0_data;
                end else if (win_d == P1) begin
                    data_q <= prod1_data;
                end
            end
            if (state_q == ISSUE) begin
                hold_q <= HOLD_LOAD;
            end else if (state_q == HOLD && hold_q != '0) begin
                hold_q <= hold_q - 1'b1;
            end
            // Read data is taken on entry to DONE so it is valid alongside cons_valid.
            if (state_q == HOLD && hold_q == '0 && win_q == C) begin
                cons_q <= fila_data_out;
            end
            if (state_q == DONE) begin
                count_q <= (win_q == C) ? count_q - 4'd1 : count_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_escalonador_fila.sv
// Bench for escalonador_fila: a behavioural FIFO device, a transaction-level
// reference model compared every cycle, and directed scenarios with literal checks.
module tb_escalonador_fila;

    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       prod0_req = 1'b0, prod1_req = 1'b0, cons_req = 1'b0;
    logic [7:0] prod0_data = 8'h00, prod1_data = 8'h00;
    logic       prod0_ack, prod1_ack, cons_valid;
    logic [7:0] cons_data, fila_data_in;
    logic [7:0] fila_data_out;
    logic       fila_enqueue, fila_dequeue;
    logic [3:0] count;
    logic       full, empty;

    escalonador_fila #(.DEPTH(8), .GAP(GAP)) dut (
        .clock_10KHz   (clk),
        .reset         (rst_n),
        .prod0_req     (prod0_req),
        .prod1_req     (prod1_req),
        .prod0_data    (prod0_data),
        .prod1_data    (prod1_data),
        .prod0_ack     (prod0_ack),
        .prod1_ack     (prod1_ack),
        .cons_req      (cons_req),
        .cons_valid    (cons_valid),
        .cons_data     (cons_data),
        .fila_data_in  (fila_data_in),
        .fila_enqueue  (fila_enqueue),
        .fila_dequeue  (fila_dequeue),
        .fila_data_out (fila_data_out),
        .count         (count),
        .full          (full),
        .empty         (empty)
    );

    always #50 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural FIFO device sharing the controller's reset.
    logic [7:0] dev_q[$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dev_q.delete();
            fila_data_out <= 8'h00;
        end else begin
            if (fila_enqueue) dev_q.push_back(fila_data_in);
            if (fila_dequeue && dev_q.size() > 0) fila_data_out <= dev_q.pop_front();
        end
    end

    // Requesters: producers hold req while their byte queue is non-empty.
    logic [7:0] q0[$], q1[$];
    int  cons_n = 0;
    bit  ack0_seen = 0, ack1_seen = 0, val_seen = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            cons_n = 0;
        end else begin
            if (ack0_seen && q0.size() > 0) void'(q0.pop_front());
            if (ack1_seen && q1.size() > 0) void'(q1.pop_front());
            if (val_seen && cons_n > 0) cons_n--;
        end
        ack0_seen = 0;
        ack1_seen = 0;
        val_seen  = 0;
        prod0_req  = (q0.size() > 0);
        prod0_data = (q0.size() > 0) ? q0[0] : 8'h00;
        prod1_req  = (q1.size() > 0);
        prod1_data = (q1.size() > 0) ? q1[0] : 8'h00;
        cons_req   = (cons_n > 0);
    end

    // Reference model: FIFO contents as a queue, a transaction as a phase count
    // (-1 idle, 0 command cycle, GAP completion cycle), round-robin by modulo search.
    logic [7:0] m_q[$];
    int         m_ph = -1;
    int         m_win = 0;
    int         m_last = 2;
    int         m_id;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_cons = 8'h00;
    bit         found;
    bit         el[3];
    int         e_cnt;
    bit         e_enq, e_deq, e_a0, e_a1, e_v;

    int         grant_log[$];
    logic [7:0] val_log[$];
    int         enq_total = 0, deq_total = 0, ev_total = 0;
    int         enq_cyc = 0, ack0_cyc = 0, req0_cyc = -1;
    logic [7:0] enq_data = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_ph   = -1;
            m_last = 2;
            m_data = 8'h00;
            m_cons = 8'h00;
        end
        e_cnt = m_q.size();
        e_enq = rst_n && (m_ph == 0) && (m_win != 2);
        e_deq = rst_n && (m_ph == 0) && (m_win == 2);
        e_a0  = rst_n && (m_ph == GAP) && (m_win == 0);
        e_a1  = rst_n && (m_ph == GAP) && (m_win == 1);
        e_v   = rst_n && (m_ph == GAP) && (m_win == 2);
        if (e_v && m_q.size() > 0) m_cons = m_q.pop_front();

        chk("enqueue", fila_enqueue, e_enq);
        chk("dequeue", fila_dequeue, e_deq);
        chk("prod0_ack", prod0_ack, e_a0);
        chk("prod1_ack", prod1_ack, e_a1);
        chk("cons_valid", cons_valid, e_v);
        chk("fila_data_in", fila_data_in, m_data);
        chk("cons_data", cons_data, m_cons);
        chk("count", count, e_cnt);
        chk("full", full, e_cnt == 8);
        chk("empty", empty, e_cnt == 0);

        if (rst_n) begin
            if (prod0_req && req0_cyc < 0) req0_cyc = cyc;
            if (fila_enqueue) begin enq_total++; enq_cyc = cyc; enq_data = fila_data_in; end
            if (fila_dequeue) deq_total++;
            if (prod0_ack) begin grant_log.push_back(0); ack0_cyc = cyc; ev_total++; ack0_seen = 1; end
            if (prod1_ack) begin grant_log.push_back(1); ev_total++; ack1_seen = 1; end
            if (cons_valid) begin grant_log.push_back(2); val_log.push_back(cons_data); ev_total++; val_seen = 1; end

            if (m_ph < 0) begin
                el[0] = prod0_req && (m_q.size() < 8);
                el[1] = prod1_req && (m_q.size() < 8);
                el[2] = cons_req && (m_q.size() > 0);
                found = 0;
                for (int k = 1; k <= 3; k++) begin
                    m_id = (m_last + k) % 3;
                    if (!found && el[m_id]) begin
                        found = 1;
                        m_win = m_id;
                    end
                end
                if (found) begin
                    m_last = m_win;
                    m_ph   = 0;
                    if (m_win == 0) m_data = prod0_data;
                    if (m_win == 1) m_data = prod1_data;
                end
            end else if (m_ph < GAP) begin
                m_ph++;
            end else begin
                if (m_win != 2) m_q.push_back(m_data);
                m_ph = -1;
            end
        end
    end

    task automatic wait_events(input int target, input int budget, input string name);
        int n = 0;
        while (ev_total < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, (ev_total >= target) ? 1 : 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        grant_log.delete();
        val_log.delete();
    endtask

    initial begin
        int base;
        int e0;
        int n;

        // Reset values, then a single P0 enqueue with latency checks.
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_cons_data", cons_data, 0);
        chk("rst_data_in", fila_data_in, 0);
        chk("rst_ack0", prod0_ack, 0);
        req0_cyc = -1;
        base = ev_total;
        @(posedge clk);
        q0.push_back(8'hA5);
        wait_events(base + 1, 20, "t1_ack_timeout");
        chk("t1_enq_latency", enq_cyc - req0_cyc, 1);
        chk("t1_ack_latency", ack0_cyc - req0_cyc, 5);
        chk("t1_enq_data", enq_data, 8'hA5);
        chk("t1_count", count, 1);

        // P0 and P1 contend: grants alternate P0, P1, P0.
        do_reset();
        base = ev_total;
        @(posedge clk);
        q0.push_back(8'h11);
        q0.push_back(8'h12);
        q1.push_back(8'h21);
        wait_events(base + 3, 40, "t2_timeout");
        chk("t2_ngrants", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            chk("t2_grant0", grant_log[0], 0);
            chk("t2_grant1", grant_log[1], 1);
            chk("t2_grant2", grant_log[2], 0);
        end
        chk("t2_count", count, 3);
        chk("t2_dev_order", (dev_q.size() == 3) ? int'(dev_q[1]) : -1, 8'h21);

        // Fill to DEPTH, P1 blocked until one dequeue frees a slot.
        do_reset();
        base = ev_total;
        @(posedge clk);
        for (int i = 0; i < 8; i++) q0.push_back(8'(8'h10 + i));
        wait_events(base + 8, 100, "t3_fill_timeout");
        chk("t3_full", full, 1);
        chk("t3_count8", count, 8);
        e0 = enq_total;
        @(posedge clk);
        q1.push_back(8'h99);
        repeat (20) @(posedge clk);
        #1;
        chk("t3_no_enq_when_full", enq_total - e0, 0);
        chk("t3_count_held", count, 8);
        chk("t3_full_held", full, 1);
        base = ev_total;
        @(posedge clk);
        cons_n = 1;
        wait_events(base + 2, 40, "t3_drain_timeout");
        chk("t3_first_c", (grant_log.size() >= 10) ? grant_log[8] : -1, 2);
        chk("t3_then_p1", (grant_log.size() >= 10) ? grant_log[9] : -1, 1);
        chk("t3_cons_data", (val_log.size() >= 1) ? int'(val_log[0]) : -1, 8'h10);
        chk("t3_count_end", count, 8);

        // Consumer blocked while empty, then receives 0x3C.
        do_reset();
        e0 = deq_total;
        @(posedge clk);
        cons_n = 1;
        repeat (15) @(posedge clk);
        #1;
        chk("t4_no_deq_when_empty", deq_total - e0, 0);
        chk("t4_empty_held", empty, 1);
        base = ev_total;
        @(posedge clk);
        q0.push_back(8'h3C);
        wait_events(base + 2, 40, "t4_timeout");
        chk("t4_cons_data", cons_data, 8'h3C);
        chk("t4_count", count, 0);
        chk("t4_empty", empty, 1);

        // count=4 with pointer on C: three-way contention gives P0, P1, C, P0.
        do_reset();
        base = ev_total;
        @(posedge clk);
        for (int i = 0; i < 5; i++) q0.push_back(8'(8'h40 + i));
        wait_events(base + 5, 80, "t5_fill_timeout");
        base = ev_total;
        @(posedge clk);
        cons_n = 1;
        wait_events(base + 1, 20, "t5_pre_timeout");
        chk("t5_pre_data", cons_data, 8'h40);
        chk("t5_pre_count", count, 4);
        base = ev_total;
        @(posedge clk);
        q0.push_back(8'h50);
        q0.push_back(8'h51);
        q1.push_back(8'h60);
        cons_n = 1;
        wait_events(base + 4, 60, "t5_timeout");
        if (grant_log.size() == 10) begin
            chk("t5_g0", grant_log[6], 0);
            chk("t5_g1", grant_log[7], 1);
            chk("t5_g2", grant_log[8], 2);
            chk("t5_g3", grant_log[9], 0);
        end else begin
            chk("t5_ngrants", grant_log.size(), 10);
        end
        chk("t5_oldest", (val_log.size() >= 2) ? int'(val_log[1]) : -1, 8'h41);
        chk("t5_count", count, 6);

        // Reset during HOLD of an enqueue aborts it without an ack.
        do_reset();
        e0 = enq_total;
        @(posedge clk);
        q0.push_back(8'h77);
        n = 0;
        while (enq_total == e0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        chk("t6_enq_seen", enq_total - e0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_data_in", fila_data_in, 0);
        chk("t6_rst_ack0", prod0_ack, 0);
        chk("t6_rst_empty", empty, 1);
        base = ev_total;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("t6_no_ack", ev_total - base, 0);
        chk("t6_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/escalonador_fila.md
# escalonador_fila

Sequencing and arbitration controller for the team's 8-entry, 8-bit FIFO. It shares the FIFO's single enqueue/dequeue port between two producers and one consumer using round-robin arbitration, and converts each granted request into a one-cycle command pulse. Because the FIFO's 3-bit length output cannot represent 8 entries, the controller keeps its own 4-bit shadow occupancy count and uses it to block enqueues when full and dequeues when empty. It sits between the requesting blocks and the FIFO, in the same clock_10KHz domain.

## Interface
- DEPTH, 8: FIFO capacity; shadow count saturates here.
- GAP, 4: cycles from command issue to completion (≥2); covers the FIFO's internal state-machine turnaround.
- clock_10KHz  in  1  system clock, 10 kHz; all logic on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset immediately.
- prod0_req / prod1_req  in  1  level request to enqueue; held until matching ack.
- prod0_data / prod1_data  in  8  byte to enqueue; stable while req is high.
- prod0_ack / prod1_ack  out  1  one-cycle pulse: byte accepted.
- cons_req  in  1  level request to dequeue; held until cons_valid.
- cons_valid  out  1  one-cycle pulse: cons_data holds the dequeued byte.
- cons_data  out  8  dequeued byte; holds its value until the next dequeue.
- fila_data_in  out  8  byte to the FIFO; stable for the whole command window.
- fila_enqueue / fila_dequeue  out  1  one-cycle command pulses to the FIFO; never both high.
- fila_data_out  in  8  FIFO read data.
- count  out  4  shadow occupancy, 0..DEPTH.
- full / empty  out  1  count==DEPTH / count==0 (combinational from count).

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ISSUE: assert the command for one cycle.
  - HOLD: wait GAP-1 cycles on a down-counter.
  - DONE: complete the transaction and update state.
- Transitions: IDLE→ISSUE when any eligible request exists; ISSUE→HOLD; HOLD→DONE when the counter reaches 0; DONE→IDLE.
- Eligibility: a producer is eligible iff req=1 and full=0; the consumer is eligible iff cons_req=1 and empty=0.
- Round-robin order is P0→P1→C. The search starts after the last granted requester and skips ineligible ones. The pointer (2 bits) updates only on a grant.
- Grant latch: the winner ID and, for a producer, its data are registered in IDLE on the grant cycle. fila_data_in is driven from this register through ISSUE, HOLD and DONE.
- DONE, enqueue: the granted producer's ack pulses; count increments.
- DONE, dequeue: fila_data_out is captured into cons_data; cons_valid pulses; count decrements.
- count changes only in DONE, so it never wraps: an enqueue at DEPTH or a dequeue at 0 cannot be granted.
- Requests arriving mid-transaction wait; no request is queued beyond its level signal.
- If req drops before ack (protocol violation), the granted transaction still completes and the ack still pulses.

## Timing
- Reset values: state IDLE, RR pointer pointing to C (so P0 is first), count 0, empty=1, full=0. All acks, cons_valid, fila_enqueue and fila_dequeue are 0; cons_data and fila_data_in are 0.
- Reset asserted mid-transaction aborts immediately; no ack or valid is produced. The FIFO must be reset by the same signal so the shadow count stays coherent.
- Latency from req sampled in IDLE to ack/valid pulse is GAP+2 cycles: 1 grant, 1 issue, GAP-1 hold, 1 done. This is 6 cycles at GAP=4.
- Back-to-back throughput is one transaction per GAP+2 cycles. IDLE lasts a single cycle when a request is pending.
- fila_enqueue/fila_dequeue are high for exactly the ISSUE cycle.
- A requester may drop req in the cycle after ack/valid. If it keeps req high, it is re-eligible in the next IDLE but loses to other pending requesters.

## Structure
- Shared package `fila_pkg`:
  - FSM state enum `estado_esc_t` (IDLE, ISSUE, HOLD, DONE).
  - Requester ID enum `req_id_t` (P0, P1, C).
  - Constants FILA_DEPTH=8 and FILA_WIDTH=8.
- One natural sub-module, `rr_arbiter3`: combinational 3-way round-robin pick from the eligibility mask and last-grant pointer, producing a one-hot grant and a valid flag.
- The top level instantiates the FIFO only in the testbench, not in this block.

## Test plan
- Reset, then P0 requests 0xA5 → fila_enqueue is one pulse 2 cycles after req with fila_data_in=0xA5; prod0_ack fires at cycle 6; count=1.
- P0 and P1 request simultaneously, each holding req high → grants alternate P0, P1, P0; count increments 1, 2, 3.
- Fill with 8 bytes, then P1 requests → no fila_enqueue; full=1 and count=8 hold. After one dequeue (cons_valid with the first byte written), P1 is granted.
- From empty, cons_req=1 → no fila_dequeue issued and empty stays 1. After P0 enqueues 0x3C, the consumer gets cons_valid with cons_data=0x3C and count returns to 0.
- P0, P1 and C all requesting with count=4 → grant order P0, P1, C, P0; cons_data equals the oldest byte.
- Reset pulled low during HOLD of an enqueue → all outputs return to reset values at once; no prod ack; count=0 after release.
